// File: rtl/led_status_driver.sv
// Registered LED output stage: latches the hasher PIO pattern and applies a display
// mode (static / blink / chase / off) with global PWM dimming to active-low pins.
module led_status_driver #(
    parameter int NUM_LEDS  = 5,
    parameter int PWM_BITS  = 8,
    parameter int BLINK_DIV = 12500000
) (
    input  logic                clk_50,
    input  logic                global_reset_n,
    input  logic [NUM_LEDS-1:0] pio_val,
    input  logic                pio_we,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] duty,
    output logic [NUM_LEDS-1:0] LED,
    output logic                step_tick
);

    localparam int                DIV_W    = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_OFF    = 2'd3
    } mode_e;

    // Reset synchronizer: assertion is immediate, release is aligned to clk_50.
    logic [1:0] rst_sync_q;
    logic [1:0] rst_sync_d;
    logic       rst_n;

    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge clk_50 or negedge global_reset_n) begin
        if (!global_reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n = rst_sync_q[1];

    // State registers
    mode_e               mode_q,      mode_d;
    logic [NUM_LEDS-1:0] pattern_q,   pattern_d;
    logic [PWM_BITS-1:0] duty_q,      duty_d;
    logic [PWM_BITS-1:0] pwm_cnt_q,   pwm_cnt_d;
    logic [DIV_W-1:0]    div_q,       div_d;
    logic                phase_q,     phase_d;
    logic [NUM_LEDS-1:0] led_q,       led_d;
    logic                step_tick_q, step_tick_d;

    logic                div_at_last;
    logic                step;
    logic                pwm_on;
    logic [NUM_LEDS-1:0] pattern_rot;
    logic [NUM_LEDS-1:0] lit;

    // Rotate-left-by-one with MSB wrapping into bit 0.
    generate
        for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_rot
            assign pattern_rot[gi] = pattern_q[(gi + NUM_LEDS - 1) % NUM_LEDS];
        end
    endgenerate

    // Step divider; a load on the terminal-count edge suppresses the step.
    always_comb begin
        div_at_last = (div_q == DIV_LAST);
        step        = div_at_last && !pio_we;
        if (pio_we || div_at_last) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
        step_tick_d = step;
    end

    // Free-running PWM; all-ones duty is a true 100 % rather than 255/256.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        pwm_on    = (duty_q == {PWM_BITS{1'b1}}) || (pwm_cnt_q < duty_q);
    end

    // Mode FSM next-state and lit-pattern decode
    always_comb begin
        mode_d    = mode_q;
        pattern_d = pattern_q;
        duty_d    = duty_q;
        phase_d   = phase_q;
        lit       = '0;

        if (pio_we) begin
            mode_d    = mode_e'(mode);
            pattern_d = pio_val;
            duty_d    = duty;
            phase_d   = 1'b1;
        end else if (step) begin
            case (mode_q)
                MODE_BLINK: phase_d   = ~phase_q;
                MODE_CHASE: pattern_d = pattern_rot;
                default:    ;
            endcase
        end

        case (mode_q)
            MODE_STATIC: lit = pattern_q;
            MODE_BLINK:  lit = phase_q ? pattern_q : '0;
            MODE_CHASE:  lit = pattern_q;
            MODE_OFF:    lit = '0;
            default:     lit = '0;
        endcase

        led_d = ~(lit & {NUM_LEDS{pwm_on}});
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_STATIC;
            pattern_q   <= '0;
            duty_q      <= '1;
            pwm_cnt_q   <= '0;
            div_q       <= '0;
            phase_q     <= 1'b1;
            led_q       <= '1;
            step_tick_q <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            pattern_q   <= pattern_d;
            duty_q      <= duty_d;
            pwm_cnt_q   <= pwm_cnt_d;
            div_q       <= div_d;
            phase_q     <= phase_d;
            led_q       <= led_d;
            step_tick_q <= step_tick_d;
        end
    end

    assign LED       = led_q;
    assign step_tick = step_tick_q;

endmodule

// File: tb/tb_led_status_driver.sv
// Directed self-checking bench for led_status_driver with BLINK_DIV = 4.
module tb_led_status_driver;

    logic       clk_50;
    logic       global_reset_n;
    logic [4:0] pio_val;
    logic       pio_we;
    logic [1:0] mode;
    logic [7:0] duty;
    logic [4:0] LED;
    logic       step_tick;

    int pass_cnt;
    int total_cnt;

    led_status_driver #(
        .NUM_LEDS  (5),
        .PWM_BITS  (8),
        .BLINK_DIV (4)
    ) dut (
        .clk_50         (clk_50),
        .global_reset_n (global_reset_n),
        .pio_val        (pio_val),
        .pio_we         (pio_we),
        .mode           (mode),
        .duty           (duty),
        .LED            (LED),
        .step_tick      (step_tick)
    );

    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    // Drives a one-cycle load; returns at the negedge following the load edge.
    task automatic do_load(input logic [4:0] v, input logic [1:0] m, input logic [7:0] d);
        @(negedge clk_50);
        pio_val = v;
        mode    = m;
        duty    = d;
        pio_we  = 1'b1;
        @(negedge clk_50);
        pio_we  = 1'b0;
        $display("load pio_val=%b mode=%0d duty=%0d", v, m, d);
    endtask

    task automatic test_reset;
        bit exp_tick;
        repeat (3) @(negedge clk_50);
        total_cnt++;
        if (LED !== 5'b11111 || step_tick !== 1'b0)
            $display("FAIL reset_state LED=%b tick=%b required LED=11111 tick=0", LED, step_tick);
        else pass_cnt++;
        global_reset_n = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk_50);
            exp_tick = (i >= 6) && ((i - 6) % 4 == 0);
            total_cnt++;
            if (step_tick !== exp_tick || LED !== 5'b11111)
                $display("FAIL reset_cadence cycle=%0d LED=%b tick=%b required LED=11111 tick=%b",
                         i, LED, step_tick, exp_tick);
            else pass_cnt++;
        end
        $display("test_reset done");
    endtask

    task automatic test_static;
        int bad;
        do_load(5'b10101, 2'd0, 8'hFF);
        total_cnt++;
        if (LED !== 5'b11111)
            $display("FAIL static_latency_early LED=%b required 11111", LED);
        else pass_cnt++;
        @(negedge clk_50);
        total_cnt++;
        if (LED !== 5'b01010)
            $display("FAIL static_first LED=%b required 01010", LED);
        else pass_cnt++;
        bad = 0;
        repeat (600) begin
            @(negedge clk_50);
            if (LED !== 5'b01010) bad++;
        end
        total_cnt++;
        if (bad !== 0)
            $display("FAIL static_hold bad_cycles=%0d required 0", bad);
        else pass_cnt++;
        $display("test_static done bad_cycles=%0d", bad);
    endtask

    task automatic test_chase;
        logic [4:0] exp_pat [5];
        exp_pat[0] = 5'b00011;
        exp_pat[1] = 5'b00110;
        exp_pat[2] = 5'b01100;
        exp_pat[3] = 5'b11000;
        exp_pat[4] = 5'b10001;
        do_load(5'b00011, 2'd2, 8'hFF);
        @(negedge clk_50);
        for (int s = 0; s < 5; s++) begin
            total_cnt++;
            if (LED !== ~exp_pat[s])
                $display("FAIL chase_step%0d_start LED=%b required %b", s, LED, ~exp_pat[s]);
            else pass_cnt++;
            repeat (3) @(negedge clk_50);
            total_cnt++;
            if (LED !== ~exp_pat[s] || step_tick !== 1'b1)
                $display("FAIL chase_step%0d_end LED=%b tick=%b required LED=%b tick=1",
                         s, LED, step_tick, ~exp_pat[s]);
            else pass_cnt++;
            @(negedge clk_50);
        end
        $display("test_chase done");
    endtask

    task automatic test_blink;
        logic [4:0] exp_led;
        do_load(5'b11111, 2'd1, 8'hFF);
        @(negedge clk_50);
        for (int s = 0; s < 4; s++) begin
            exp_led = (s % 2 == 0) ? 5'b00000 : 5'b11111;
            total_cnt++;
            if (LED !== exp_led)
                $display("FAIL blink_phase%0d_start LED=%b required %b", s, LED, exp_led);
            else pass_cnt++;
            repeat (3) @(negedge clk_50);
            total_cnt++;
            if (LED !== exp_led)
                $display("FAIL blink_phase%0d_end LED=%b required %b", s, LED, exp_led);
            else pass_cnt++;
            @(negedge clk_50);
        end
        $display("test_blink done");
    endtask

    task automatic test_pwm;
        int lit_cnt;
        int hi_bad;
        do_load(5'b00001, 2'd0, 8'd64);
        @(negedge clk_50);
        lit_cnt = 0;
        hi_bad  = 0;
        repeat (256) begin
            @(negedge clk_50);
            if (LED[0] === 1'b0) lit_cnt++;
            if (LED[4:1] !== 4'hF) hi_bad++;
        end
        total_cnt++;
        if (lit_cnt !== 64 || hi_bad !== 0)
            $display("FAIL pwm_duty64 lit=%0d hi_bad=%0d required lit=64 hi_bad=0", lit_cnt, hi_bad);
        else pass_cnt++;
        $display("pwm duty=64 lit_cycles=%0d", lit_cnt);

        do_load(5'b00001, 2'd0, 8'd0);
        @(negedge clk_50);
        lit_cnt = 0;
        repeat (256) begin
            @(negedge clk_50);
            if (LED[0] === 1'b0) lit_cnt++;
        end
        total_cnt++;
        if (lit_cnt !== 0)
            $display("FAIL pwm_duty0 lit=%0d required 0", lit_cnt);
        else pass_cnt++;
        $display("pwm duty=0 lit_cycles=%0d", lit_cnt);
    endtask

    task automatic test_back_to_back;
        bit exp_tick;
        do_load(5'b00011, 2'd2, 8'hFF);
        // Divider now at 0; three more edges put it at terminal count.
        repeat (3) @(negedge clk_50);
        pio_val = 5'b00011;
        mode    = 2'd2;
        duty    = 8'hFF;
        pio_we  = 1'b1;
        @(negedge clk_50);
        pio_we  = 1'b0;
        total_cnt++;
        if (step_tick !== 1'b0 || LED !== ~5'b00011)
            $display("FAIL tc_load_edge LED=%b tick=%b required LED=%b tick=0", LED, step_tick, ~5'b00011);
        else pass_cnt++;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk_50);
            exp_tick = (i == 4);
            total_cnt++;
            if (step_tick !== exp_tick || LED !== ~5'b00011)
                $display("FAIL tc_restart cycle=%0d LED=%b tick=%b required LED=%b tick=%b",
                         i, LED, step_tick, ~5'b00011, exp_tick);
            else pass_cnt++;
        end
        @(negedge clk_50);
        total_cnt++;
        if (LED !== ~5'b00110)
            $display("FAIL tc_next_rotate LED=%b required %b", LED, ~5'b00110);
        else pass_cnt++;
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid;
        bit exp_tick;
        @(posedge clk_50);
        #2 global_reset_n = 1'b0;
        #1;
        total_cnt++;
        if (LED !== 5'b11111 || step_tick !== 1'b0)
            $display("FAIL mid_reset_async LED=%b tick=%b required LED=11111 tick=0", LED, step_tick);
        else pass_cnt++;
        @(negedge clk_50);
        global_reset_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_50);
            exp_tick = (i >= 6) && ((i - 6) % 4 == 0);
            total_cnt++;
            if (step_tick !== exp_tick || LED !== 5'b11111)
                $display("FAIL mid_reset_after cycle=%0d LED=%b tick=%b required LED=11111 tick=%b",
                         i, LED, step_tick, exp_tick);
            else pass_cnt++;
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        pass_cnt       = 0;
        total_cnt      = 0;
        global_reset_n = 1'b0;
        pio_val        = '0;
        pio_we         = 1'b0;
        mode           = '0;
        duty           = '0;
        test_reset();
        test_static();
        test_chase();
        test_blink();
        test_pwm();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
